// File: rtl/spider_gadget_scheduler.sv
// Round-robin scheduler sharing the suit's web/energy/tracer pool among the taser, tracer and web-shot gadgets.
// Optional energy recharge is enabled by defining SPIDER_ENERGY_RECHARGE_EN.
module spider_gadget_scheduler #(
   parameter int WEB_MAX         = 15,
   parameter int ENERGY_MAX      = 255,
   parameter int TRACER_MAX      = 63,
   parameter int COOLDOWN_CYCLES = 4,
   parameter int RECHARGE_PERIOD = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic       refill,
   output logic [2:0] grant,
   output logic [2:0] denied,
   output logic       busy,
   output logic [3:0] web_level,
   output logic [7:0] energy_level,
   output logic [5:0] tracer_level
);

   typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;

   localparam int CW = $clog2(COOLDOWN_CYCLES + 2);

   state_t        state_q, state_d;
   logic [1:0]    rrPtr_q, rrPtr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    grant_q, grant_d;
   logic [2:0]    denied_q, denied_d;
   logic [3:0]    web_q, web_d;
   logic [7:0]    energy_q, energy_d;
   logic [5:0]    tracer_q, tracer_d;

   logic [1:0]    sel;
   logic [2:0]    selOneHot;
   logic [3:0]    costWeb;
   logic [7:0]    costEnergy;
   logic [5:0]    costTracer;
   logic          sufficient;

   // First requester at or after the round-robin pointer, wrapping 2 -> 0.
   function automatic logic [1:0] pickNext(input logic [2:0] r, input logic [1:0] p);
      logic [1:0] result;
      logic       found;
      int         idx;
      result = p;
      found  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         idx = (int'(p) + k) % 3;
         if (!found && r[idx]) begin
            result = 2'(idx);
            found  = 1'b1;
         end
      end
      return result;
   endfunction

   always_comb begin
      sel       = pickNext(req, rrPtr_q);
      selOneHot = 3'b001 << sel;
      case (sel)
         2'd0:    begin costWeb = 4'd1;  costEnergy = 8'd16; costTracer = 6'd8; end
         2'd1:    begin costWeb = 4'd1;  costEnergy = 8'd1;  costTracer = 6'd4; end
         default: begin costWeb = 4'd15; costEnergy = 8'd4;  costTracer = 6'd0; end
      endcase
      sufficient = (web_q >= costWeb) && (energy_q >= costEnergy) && (tracer_q >= costTracer);
   end

`ifdef SPIDER_ENERGY_RECHARGE_EN
   localparam int RW = $clog2(RECHARGE_PERIOD + 1);
   logic [RW-1:0] recharge_q, recharge_d;
   logic          rechargeTick;

   always_comb begin
      rechargeTick = (recharge_q == RW'(RECHARGE_PERIOD - 1));
      recharge_d   = rechargeTick ? '0 : recharge_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) recharge_q <= '0;
      else       recharge_q <= recharge_d;
   end
`endif

   always_comb begin
      state_d  = state_q;
      rrPtr_d  = rrPtr_q;
      cnt_d    = cnt_q;
      grant_d  = 3'b000;
      denied_d = 3'b000;
      web_d    = web_q;
      energy_d = energy_q;
      tracer_d = tracer_q;
      case (state_q)
         IDLE: begin
            if (req != 3'b000) begin
               rrPtr_d = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
               if (sufficient) begin
                  state_d  = GRANT;
                  grant_d  = selOneHot;
                  web_d    = web_q - costWeb;
                  energy_d = energy_q - costEnergy;
                  tracer_d = tracer_q - costTracer;
               end else begin
                  denied_d = selOneHot;
               end
            end
         end
         GRANT: begin
            if (COOLDOWN_CYCLES > 0) begin
               state_d = COOLDOWN;
               cnt_d   = CW'(COOLDOWN_CYCLES);
            end else begin
               state_d = IDLE;
            end
         end
         COOLDOWN: begin
            if (cnt_q <= CW'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef SPIDER_ENERGY_RECHARGE_EN
      // A deduction always leaves energy below max, so +1 here cannot overflow.
      if (rechargeTick && energy_d != 8'(ENERGY_MAX)) energy_d = energy_d + 8'd1;
`endif
      if (refill) begin
         web_d    = 4'(WEB_MAX);
         energy_d = 8'(ENERGY_MAX);
         tracer_d = 6'(TRACER_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         rrPtr_q  <= 2'd0;
         cnt_q    <= '0;
         grant_q  <= 3'b000;
         denied_q <= 3'b000;
         web_q    <= 4'(WEB_MAX);
         energy_q <= 8'(ENERGY_MAX);
         tracer_q <= 6'(TRACER_MAX);
      end else begin
         state_q  <= state_d;
         rrPtr_q  <= rrPtr_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         denied_q <= denied_d;
         web_q    <= web_d;
         energy_q <= energy_d;
         tracer_q <= tracer_d;
      end
   end

   assign grant        = grant_q;
   assign denied       = denied_q;
   assign busy         = (state_q != IDLE);
   assign web_level    = web_q;
   assign energy_level = energy_q;
   assign tracer_level = tracer_q;

endmodule

// File: tb/tb_spider_gadget_scheduler.sv
// Directed self-checking bench for spider_gadget_scheduler in its default build (COOLDOWN_CYCLES=4).
module tb_spider_gadget_scheduler;

   logic       clk;
   logic       reset;
   logic [2:0] req;
   logic       refill;
   logic [2:0] grant;
   logic [2:0] denied;
   logic       busy;
   logic [3:0] web_level;
   logic [7:0] energy_level;
   logic [5:0] tracer_level;

   int checks   = 0;
   int failures = 0;

   spider_gadget_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .refill       (refill),
      .grant        (grant),
      .denied       (denied),
      .busy         (busy),
      .web_level    (web_level),
      .energy_level (energy_level),
      .tracer_level (tracer_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs, then advance one rising edge and settle so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic rst, input logic [2:0] r, input logic rf, input int cycles);
      reset  = rst;
      req    = r;
      refill = rf;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkLevels(input string tag, input int w, input int e, input int t);
      checkOutput({tag, "_web"},    32'(web_level),    32'(w));
      checkOutput({tag, "_energy"}, 32'(energy_level), 32'(e));
      checkOutput({tag, "_tracer"}, 32'(tracer_level), 32'(t));
   endtask

   initial begin
      reset  = 1'b1;
      req    = 3'b000;
      refill = 1'b0;

      // Reset state
      applyStimulus(1'b1, 3'b000, 1'b0, 2);
      checkOutput("rst_grant",  32'(grant),  32'h0);
      checkOutput("rst_denied", 32'(denied), 32'h0);
      checkOutput("rst_busy",   32'(busy),   32'h0);
      checkLevels("rst", 15, 255, 63);

      // All three requesting: taser, tracer, web denied, taser again
      $display("[TB] round-robin with all requests held");
      applyStimulus(1'b0, 3'b111, 1'b0, 1);
      checkOutput("rr1_grant", 32'(grant), 32'h1);
      checkOutput("rr1_busy",  32'(busy),  32'h1);
      checkLevels("rr1", 14, 239, 55);
      applyStimulus(1'b0, 3'b111, 1'b0, 4);
      checkOutput("rr1_cool_busy",  32'(busy),  32'h1);
      checkOutput("rr1_cool_grant", 32'(grant), 32'h0);
      applyStimulus(1'b0, 3'b111, 1'b0, 1);
      checkOutput("rr1_idle_busy", 32'(busy), 32'h0);
      applyStimulus(1'b0, 3'b111, 1'b0, 1);
      checkOutput("rr2_grant", 32'(grant), 32'h2);
      checkLevels("rr2", 13, 238, 51);
      applyStimulus(1'b0, 3'b111, 1'b0, 6);
      checkOutput("rr3_denied", 32'(denied), 32'h4);
      checkOutput("rr3_grant",  32'(grant),  32'h0);
      checkOutput("rr3_busy",   32'(busy),   32'h0);
      checkLevels("rr3", 13, 238, 51);
      applyStimulus(1'b0, 3'b111, 1'b0, 1);
      checkOutput("rr4_grant",  32'(grant),  32'h1);
      checkOutput("rr4_denied", 32'(denied), 32'h0);
      checkLevels("rr4", 12, 222, 43);

      // Web shot alone, stock-out, then refill
      $display("[TB] web shot stock-out and refill");
      applyStimulus(1'b1, 3'b000, 1'b0, 1);
      applyStimulus(1'b0, 3'b100, 1'b0, 1);
      checkOutput("web1_grant", 32'(grant), 32'h4);
      checkLevels("web1", 0, 251, 63);
      applyStimulus(1'b0, 3'b100, 1'b0, 6);
      checkOutput("web2_denied", 32'(denied), 32'h4);
      checkOutput("web2_grant",  32'(grant),  32'h0);
      checkLevels("web2", 0, 251, 63);
      applyStimulus(1'b0, 3'b000, 1'b1, 1);
      checkLevels("refill", 15, 255, 63);
      applyStimulus(1'b0, 3'b100, 1'b0, 1);
      checkOutput("web3_grant", 32'(grant), 32'h4);
      checkLevels("web3", 0, 251, 63);

      // Taser until tracer magazine runs dry
      $display("[TB] taser exhaustion");
      applyStimulus(1'b1, 3'b000, 1'b0, 1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 3'b001, 1'b0, 1);
         checkOutput($sformatf("taser%0d_grant", i), 32'(grant), 32'h1);
         applyStimulus(1'b0, 3'b001, 1'b0, 5);
      end
      checkLevels("taser7", 8, 143, 7);
      applyStimulus(1'b0, 3'b001, 1'b0, 1);
      checkOutput("taser8_denied", 32'(denied), 32'h1);
      checkOutput("taser8_grant",  32'(grant),  32'h0);
      checkOutput("taser8_busy",   32'(busy),   32'h0);
      checkLevels("taser8", 8, 143, 7);

      // Reset in the second cooldown cycle
      $display("[TB] reset during cooldown");
      applyStimulus(1'b1, 3'b000, 1'b0, 1);
      applyStimulus(1'b0, 3'b010, 1'b0, 1);
      checkOutput("cdr_grant", 32'(grant), 32'h2);
      applyStimulus(1'b0, 3'b000, 1'b0, 2);
      checkOutput("cdr_busy_before", 32'(busy), 32'h1);
      applyStimulus(1'b1, 3'b000, 1'b0, 1);
      checkOutput("cdr_busy_after", 32'(busy), 32'h0);
      checkLevels("cdr", 15, 255, 63);
      applyStimulus(1'b0, 3'b111, 1'b0, 1);
      checkOutput("cdr_ptr_grant", 32'(grant), 32'h1);

      // Refill coinciding with a taser grant
      $display("[TB] refill on grant edge");
      applyStimulus(1'b1, 3'b000, 1'b0, 1);
      applyStimulus(1'b0, 3'b001, 1'b1, 1);
      checkOutput("rfg_grant", 32'(grant), 32'h1);
      checkOutput("rfg_busy",  32'(busy),  32'h1);
      checkLevels("rfg", 15, 255, 63);
      applyStimulus(1'b0, 3'b000, 1'b0, 1);
      checkOutput("rfg_grant_once", 32'(grant), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
